// File: rtl/prio_encoder_n_pkg.sv
// prio_encoder_n_pkg: default request width and index-width helper for prio_encoder_n
package prio_encoder_n_pkg;
  localparam int N_DEF = 8;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_encoder_n_core.sv
// prio_encoder_n_core: find-first set bit searching start, start-1, ..., 0, N-1, ..., start+1
module prio_encoder_n_core
  import prio_encoder_n_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] in,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (in[(int'(start) + N - i) % N]) begin
        idx = W'((int'(start) + N - i) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prio_encoder_n.sv
// prio_encoder_n: registered priority encoder with valid/ready; PRIO_ENCODER_N_RR_EN selects round-robin priority
module prio_encoder_n
  import prio_encoder_n_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_any,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] start, idx;
  logic         hit, acc;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
`ifdef PRIO_ENCODER_N_RR_EN
  logic [W-1:0] ptr;
  assign start = ptr;
  always_ff @(posedge clk) begin
    if (rst) ptr <= W'(N - 1);
    else if (acc && en && hit) ptr <= (idx == '0) ? W'(N - 1) : idx - 1'b1;
  end
`else
  assign start = W'(N - 1);
`endif
  prio_encoder_n_core #(.N(N)) u_core (.in(in), .start(start), .idx(idx), .any(hit));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_any   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out       <= (en && hit) ? idx : '0;
      out_any   <= en && hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_n.sv
// tb_prio_encoder_n: directed self-checking bench for prio_encoder_n (N=8 and N=16 instances)
module tb_prio_encoder_n;
  logic clk = 1'b0, rst = 1'b0;
  logic en = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in = '0;
  logic in_ready, out_any, out_valid;
  logic [2:0] out;
  logic in_valid16 = 1'b0;
  logic [15:0] in16 = '0;
  logic in_ready16, out_any16, out_valid16;
  logic [3:0] out16;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  prio_encoder_n #(.N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_any(out_any), .out_valid(out_valid), .out_ready(out_ready)
  );
  prio_encoder_n #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .en(1'b1), .in(in16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out(out16), .out_any(out_any16), .out_valid(out_valid16), .out_ready(1'b1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (out !== 3'd0) begin $display("FAIL reset_out got=%0d exp=0", out); errors++; end
    checks++; if (out_any !== 1'b0) begin $display("FAIL reset_any got=%b exp=0", out_any); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", in_ready); errors++; end
  endtask

  task automatic test_sweep();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 8'(1 << i); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin $display("FAIL sweep_ready[%0d] got=%b exp=1", i, in_ready); errors++; end
      step();
      checks++;
      if (out !== 3'(i) || out_any !== 1'b1 || out_valid !== 1'b1) begin
        $display("FAIL sweep[%0d] got out=%0d any=%b valid=%b exp out=%0d any=1 valid=1", i, out, out_any, out_valid, i);
        errors++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_disable();
    en = 1'b0; in = 8'hff; in_valid = 1'b1;
    step();
    checks++;
    if (out !== 3'd0 || out_any !== 1'b0 || out_valid !== 1'b1) begin
      $display("FAIL disable got out=%0d any=%b valid=%b exp out=0 any=0 valid=1", out, out_any, out_valid);
      errors++;
    end
    en = 1'b1; in = 8'h00;
    step();
    checks++;
    if (out !== 3'd0 || out_any !== 1'b0 || out_valid !== 1'b1) begin
      $display("FAIL zero_in got out=%0d any=%b valid=%b exp out=0 any=0 valid=1", out, out_any, out_valid);
      errors++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    en = 1'b1; out_ready = 1'b1; in = 8'b0010_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out !== 3'd5 || out_valid !== 1'b1 || out_any !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold[%0d] got out=%0d valid=%b any=%b ready=%b exp out=5 valid=1 any=1 ready=0",
                 c, out, out_valid, out_any, in_ready);
        errors++;
      end
    end
    out_ready = 1'b1; in = 8'b0100_0000; in_valid = 1'b1;
    step();
    checks++;
    if (out !== 3'd6 || out_valid !== 1'b1) begin
      $display("FAIL bp_release got out=%0d valid=%b exp out=6 valid=1", out, out_valid);
      errors++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== 3'd6 || out_any !== 1'b1) begin
      $display("FAIL drain got valid=%b out=%0d any=%b exp valid=0 out=6 any=1", out_valid, out, out_any);
      errors++;
    end
  endtask

  task automatic test_reset_in_flight();
    in = 8'b0000_1000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin $display("FAIL flight_pre got valid=%b exp=1", out_valid); errors++; end
    in = 8'h80; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out !== 3'd0 || out_any !== 1'b0) begin
      $display("FAIL flight_rst got valid=%b out=%0d any=%b exp valid=0 out=0 any=0", out_valid, out, out_any);
      errors++;
    end
    step();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL flight_drop got valid=%b exp=0", out_valid); errors++; end
  endtask

  task automatic test_rr();
    logic [2:0] exp [3];
`ifdef PRIO_ENCODER_N_RR_EN
    exp = '{3'd7, 3'd0, 3'd7};
`else
    exp = '{3'd7, 3'd7, 3'd7};
`endif
    en = 1'b1; out_ready = 1'b1; in = 8'b1000_0001; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      checks++;
      if (out !== exp[b] || out_any !== 1'b1) begin
        $display("FAIL rr[%0d] got out=%0d any=%b exp out=%0d any=1", b, out, out_any, exp[b]);
        errors++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_n16();
    in16 = 16'h8000; in_valid16 = 1'b1;
    step();
    checks++;
    if (out16 !== 4'd15 || out_any16 !== 1'b1 || out_valid16 !== 1'b1) begin
      $display("FAIL n16_top got out=%0d any=%b valid=%b exp out=15 any=1 valid=1", out16, out_any16, out_valid16);
      errors++;
    end
    in16 = 16'h0001;
    step();
    checks++;
    if (out16 !== 4'd0 || out_any16 !== 1'b1 || in_ready16 !== 1'b1) begin
      $display("FAIL n16_bot got out=%0d any=%b ready=%b exp out=0 any=1 ready=1", out16, out_any16, in_ready16);
      errors++;
    end
    in_valid16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_disable();
    test_backpressure();
    test_reset_in_flight();
    test_rr();
    test_n16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
